// File: rtl/cs_measure_accum.sv
// Compressive-sensing engine: y[m] = sum_n phi(m,n)*x[n], with phi being +/-1 bits from a 16-bit LFSR; one sample per 1+M_MEAS cycles.
// Streams M_MEAS saturated bytes over valid/ready, holding data under backpressure. CS_ROUND_EN selects round-half-up before the shift.
module cs_measure_accum #(
  parameter int          N_SAMPLES = 256,
  parameter int          M_MEAS    = 64,
  parameter int          ACC_W     = 18,
  parameter int          SHIFT     = 8,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] sample_data,
  output logic       sample_ready,
  output logic       meas_valid,
  output logic [7:0] meas_data,
  input  logic       meas_ready,
  output logic       frame_done
);

  localparam int NW = $clog2(N_SAMPLES);
  localparam int MW = $clog2(M_MEAS);
  localparam logic [NW-1:0] N_LAST = NW'(N_SAMPLES - 1);
  localparam logic [MW-1:0] M_LAST = MW'(M_MEAS - 1);

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(127);
  localparam logic signed [ACC_W:0] SAT_LO = -(ACC_W+1)'(128);
`ifdef CS_ROUND_EN
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'((2 ** SHIFT) >> 1);
`endif

  logic [1:0]              r_state;
  logic [NW-1:0]           r_n_idx;
  logic [MW-1:0]           r_m_idx;
  logic [MW-1:0]           r_o_idx;
  logic [15:0]             r_lfsr;
  logic [7:0]              r_x;
  logic                    r_meas_valid;
  logic [7:0]              r_meas_data;
  logic signed [ACC_W-1:0] r_acc [M_MEAS];

  logic signed [ACC_W-1:0] w_x_ext;
  logic signed [ACC_W-1:0] w_term;
  logic [MW-1:0]           w_o_next;
  logic                    w_last_xfer;

  function automatic logic [7:0] f_scale(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] v;
    v = {a[ACC_W-1], a};
`ifdef CS_ROUND_EN
    v = v + RND;
`endif
    v = v >>> SHIFT;
    if (v > SAT_HI)      f_scale = 8'h7F;
    else if (v < SAT_LO) f_scale = 8'h80;
    else                 f_scale = v[7:0];
  endfunction

  assign w_x_ext     = {{(ACC_W-8){r_x[7]}}, r_x};
  assign w_term      = r_lfsr[0] ? w_x_ext : -w_x_ext;
  assign w_o_next    = r_o_idx + 1'b1;
  assign w_last_xfer = r_meas_valid && meas_ready && (r_o_idx == M_LAST);

  assign sample_ready = (r_state == S_WAIT);
  assign meas_valid   = r_meas_valid;
  assign meas_data    = r_meas_data;
  assign frame_done   = w_last_xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_WAIT;
      r_n_idx      <= '0;
      r_m_idx      <= '0;
      r_o_idx      <= '0;
      r_lfsr       <= SEED;
      r_x          <= '0;
      r_meas_valid <= 1'b0;
      r_meas_data  <= '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (sample_valid) begin
            r_x     <= sample_data;
            r_m_idx <= '0;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          r_lfsr  <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
          r_m_idx <= r_m_idx + 1'b1;
          if (r_m_idx == M_LAST) begin
            if (r_n_idx == N_LAST) begin
              r_o_idx <= '0;
              r_state <= S_OUT;
            end else begin
              r_n_idx <= r_n_idx + 1'b1;
              r_state <= S_WAIT;
            end
          end
        end
        S_OUT: begin
          // First cycle in S_OUT primes index 0; later loads follow each transfer.
          if (!r_meas_valid) begin
            r_meas_data  <= f_scale(r_acc[r_o_idx]);
            r_meas_valid <= 1'b1;
          end else if (meas_ready) begin
            if (r_o_idx == M_LAST) begin
              r_meas_valid <= 1'b0;
              r_n_idx      <= '0;
              r_lfsr       <= SEED;
              r_state      <= S_WAIT;
            end else begin
              r_o_idx     <= w_o_next;
              r_meas_data <= f_scale(r_acc[w_o_next]);
            end
          end
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

  // The first sample overwrites each accumulator, so no clear pass is needed.
  always_ff @(posedge clk) begin
    if (r_state == S_ACC) begin
      if (r_n_idx == '0) r_acc[r_m_idx] <= w_term;
      else               r_acc[r_m_idx] <= r_acc[r_m_idx] + w_term;
    end
  end

endmodule
